// File: rtl/lcd_bus_arbiter_pkg.sv
// Shared definitions for the character-LCD bus arbiter: FSM states,
// controller command bytes, default window lengths and small helpers.
package lcd_pkg;

    typedef enum logic [1:0] {
        INIT_WAIT = 2'd0,
        INIT_CMD  = 2'd1,
        IDLE      = 2'd2,
        WRITE     = 2'd3
    } lcd_state_t;

    localparam logic [7:0] FUNC_SET   = 8'h3C;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] ENTRY_MODE = 8'h06;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] HOME       = 8'h02;

    localparam int INIT_DELAY_DEF = 70;
    localparam int CMD_HOLD_DEF   = 30;
    localparam int WR_HOLD_DEF    = 20;
    localparam int CLR_HOLD_DEF   = 200;

    // Power-up command byte for a given step of the init sequence.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = FUNC_SET;
            2'd1:    cmd = DISP_ON;
            2'd2:    cmd = ENTRY_MODE;
            2'd3:    cmd = CLEAR;
            default: cmd = CLEAR;
        endcase
        return cmd;
    endfunction

    // Clear and return-home commands need the long execution window.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && ((data == CLEAR) || (data == HOME));
    endfunction

endpackage

// File: rtl/lcd_bus_arbiter_write_timer.sv
// Window timer shared by init commands and requester writes: counts a
// loaded hold length 0..H-1, drives the LCD enable high for counts
// 1..H/2 and flags the last cycle of the window.
module lcd_write_timer #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             load,
    input  logic [CNT_W-1:0] hold_len,
    output logic             done,
    output logic             lcd_e
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] hold_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             busy_r;
    logic             e_r;
    logic             last_s;

    // Next count value and last-cycle detection for the running window.
    always_comb begin
        cnt_inc_s = cnt_r + CNT_ONE;
        last_s    = busy_r && (cnt_r == (hold_r - CNT_ONE));
    end

    // Window counter; the enable is registered alongside the count it belongs to.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt_r  <= '0;
            hold_r <= '0;
            busy_r <= 1'b0;
            e_r    <= 1'b0;
        end else if (load) begin
            cnt_r  <= '0;
            hold_r <= hold_len;
            busy_r <= 1'b1;
            e_r    <= 1'b0;
        end else if (last_s) begin
            cnt_r  <= '0;
            busy_r <= 1'b0;
            e_r    <= 1'b0;
        end else if (busy_r) begin
            cnt_r  <= cnt_inc_s;
            e_r    <= (cnt_inc_s <= {1'b0, hold_r[CNT_W-1:1]});
        end else begin
            cnt_r  <= cnt_r;
        end
    end

    assign done  = last_s;
    assign lcd_e = e_r;

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Character-LCD bus owner: runs the power-up command sequence, then
// grants single-byte writes from two requesters and times each byte on
// the bus. Define LCD_ARB_FIXED_PRIO_EN to make requester 0 always win
// a tie; otherwise ties are resolved round-robin.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int INIT_DELAY = INIT_DELAY_DEF,
    parameter int CMD_HOLD   = CMD_HOLD_DEF,
    parameter int WR_HOLD    = WR_HOLD_DEF,
    parameter int CLR_HOLD   = CLR_HOLD_DEF
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       init_done,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam int MAX_A    = (CMD_HOLD > WR_HOLD) ? CMD_HOLD : WR_HOLD;
    localparam int MAX_HOLD = (MAX_A > CLR_HOLD) ? MAX_A : CLR_HOLD;
    localparam int CNT_W    = $clog2(MAX_HOLD + 1);
    localparam int DLY_W    = $clog2(INIT_DELAY + 1);

    localparam logic [CNT_W-1:0] CMD_HOLD_C = CNT_W'(CMD_HOLD);
    localparam logic [CNT_W-1:0] WR_HOLD_C  = CNT_W'(WR_HOLD);
    localparam logic [CNT_W-1:0] CLR_HOLD_C = CNT_W'(CLR_HOLD);
    localparam logic [DLY_W-1:0] DLY_LAST   = DLY_W'(INIT_DELAY - 1);
    localparam logic [DLY_W-1:0] DLY_ONE    = {{(DLY_W-1){1'b0}}, 1'b1};

    lcd_state_t       state_r;
    lcd_state_t       state_nxt_s;
    logic [DLY_W-1:0] dly_cnt_r;
    logic [1:0]       init_idx_r;
    logic             init_done_r;
    logic             lcd_rs_r;
    logic             lcd_rw_r;
    logic [7:0]       lcd_data_r;

    logic             dly_last_s;
    logic             init_last_s;
    logic             any_valid_s;
    logic             grant_s;
    logic             sel_rs_s;
    logic [7:0]       sel_data_s;
    logic             load_s;
    logic [CNT_W-1:0] hold_len_s;
    logic             win_rs_s;
    logic [7:0]       win_data_s;
    logic             done_s;
    logic             lcd_e_s;

`ifndef LCD_ARB_FIXED_PRIO_EN
    logic             last_grant_r;
`endif

    lcd_write_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .load     (load_s),
        .hold_len (hold_len_s),
        .done     (done_s),
        .lcd_e    (lcd_e_s)
    );

    // Arbitration between the two requesters and selection of the winning byte.
    always_comb begin
        any_valid_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef LCD_ARB_FIXED_PRIO_EN
            grant_s = 1'b0;
`else
            grant_s = ~last_grant_r;
`endif
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            sel_rs_s   = req1_rs;
            sel_data_s = req1_data;
        end else begin
            sel_rs_s   = req0_rs;
            sel_data_s = req0_data;
        end
        dly_last_s  = (dly_cnt_r == DLY_LAST);
        init_last_s = (init_idx_r == 2'd3);
    end

    // State register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_r <= INIT_WAIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            INIT_WAIT: begin
                if (dly_last_s) state_nxt_s = INIT_CMD;
                else            state_nxt_s = INIT_WAIT;
            end
            INIT_CMD: begin
                if (done_s && init_last_s) state_nxt_s = IDLE;
                else                       state_nxt_s = INIT_CMD;
            end
            IDLE: begin
                if (any_valid_s) state_nxt_s = WRITE;
                else             state_nxt_s = IDLE;
            end
            WRITE: begin
                if (done_s) state_nxt_s = IDLE;
                else        state_nxt_s = WRITE;
            end
            default: state_nxt_s = INIT_WAIT;
        endcase
    end

    // Output logic: ready strobes and the byte/window to load into the timer.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        load_s     = 1'b0;
        win_rs_s   = 1'b0;
        win_data_s = 8'h00;
        hold_len_s = WR_HOLD_C;
        case (state_r)
            INIT_WAIT: begin
                if (dly_last_s) begin
                    load_s     = 1'b1;
                    win_data_s = init_cmd(2'd0);
                    hold_len_s = is_long_cmd(1'b0, init_cmd(2'd0)) ? CLR_HOLD_C : CMD_HOLD_C;
                end else begin
                    load_s     = 1'b0;
                end
            end
            INIT_CMD: begin
                if (done_s && !init_last_s) begin
                    load_s     = 1'b1;
                    win_data_s = init_cmd(init_idx_r + 2'd1);
                    hold_len_s = is_long_cmd(1'b0, init_cmd(init_idx_r + 2'd1)) ? CLR_HOLD_C : CMD_HOLD_C;
                end else begin
                    load_s     = 1'b0;
                end
            end
            IDLE: begin
                if (any_valid_s) begin
                    load_s     = 1'b1;
                    win_rs_s   = sel_rs_s;
                    win_data_s = sel_data_s;
                    hold_len_s = is_long_cmd(sel_rs_s, sel_data_s) ? CLR_HOLD_C : WR_HOLD_C;
                    req0_ready = ~grant_s;
                    req1_ready = grant_s;
                end else begin
                    load_s     = 1'b0;
                end
            end
            WRITE: begin
                load_s = 1'b0;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Power-up delay counter and init command index.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            dly_cnt_r  <= '0;
            init_idx_r <= 2'd0;
        end else begin
            if (state_r == INIT_WAIT && !dly_last_s) begin
                dly_cnt_r <= dly_cnt_r + DLY_ONE;
            end else begin
                dly_cnt_r <= '0;
            end
            if (state_r == INIT_CMD && done_s && !init_last_s) begin
                init_idx_r <= init_idx_r + 2'd1;
            end else if (state_r == INIT_WAIT) begin
                init_idx_r <= 2'd0;
            end else begin
                init_idx_r <= init_idx_r;
            end
        end
    end

    // LCD pin registers and sticky init_done; RS/DATA hold between windows.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            lcd_rs_r    <= 1'b0;
            lcd_rw_r    <= 1'b1;
            lcd_data_r  <= 8'h00;
            init_done_r <= 1'b0;
        end else begin
            if (load_s) begin
                lcd_rs_r   <= win_rs_s;
                lcd_data_r <= win_data_s;
                lcd_rw_r   <= 1'b0;
            end else if (done_s && (state_r == INIT_CMD || state_r == WRITE)) begin
                lcd_rw_r   <= 1'b1;
            end else begin
                lcd_rw_r   <= lcd_rw_r;
            end
            if (state_r == INIT_CMD && done_s && init_last_s) begin
                init_done_r <= 1'b1;
            end else begin
                init_done_r <= init_done_r;
            end
        end
    end

`ifndef LCD_ARB_FIXED_PRIO_EN
    // Remember the last winner so the other requester wins the next tie.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            last_grant_r <= 1'b1;
        end else if (state_r == IDLE && any_valid_s) begin
            last_grant_r <= grant_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    assign init_done = init_done_r;
    assign LCD_E     = lcd_e_s;
    assign LCD_RS    = lcd_rs_r;
    assign LCD_RW    = lcd_rw_r;
    assign LCD_DATA  = lcd_data_r;

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Owns the character-LCD bus (LCD_E/RS/RW/DATA) and shares it between two write requesters, e.g. a score panel and a message panel.
- After reset, runs the controller power-up command sequence without any requester involvement.
- Then grants single-byte command/data writes round-robin and holds each byte for a fixed window with a generated enable pulse.
- Requesters never touch LCD timing.

Parameters:
- INIT_DELAY, 70: idle cycles after reset before the first init command.
- CMD_HOLD, 30: window length in cycles for each init command except clear.
- WR_HOLD, 20: window length in cycles for a requester write.
- CLR_HOLD, 200: window length for a clear (0x01) or return-home (0x02) command, whether init or requested.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESETN  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_rs  in  1  requester 0 register select: 0 = command, 1 = data.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_valid / req1_rs / req1_data / req1_ready: same as requester 0.
- init_done  out  1  power-up sequence complete; sticky until reset.
- LCD_E  out  1  LCD enable strobe.
- LCD_RS  out  1  LCD register select.
- LCD_RW  out  1  LCD read/write; 0 = write.
- LCD_DATA  out  8  LCD data bus.

Behaviour:
- Reset (RESETN low, asynchronous):
  - State INIT_WAIT, counter 0, init index 0, last_grant = 1 so requester 0 wins the first tie.
  - init_done=0, LCD_E=0, LCD_RS=0, LCD_RW=1, LCD_DATA=0x00.
  - Both ready outputs 0.
- All LCD outputs and init_done are registered. readyN is combinational from state, grant and valid.
- INIT_WAIT: count INIT_DELAY cycles with outputs at reset values, then go to INIT_CMD.
- INIT_CMD: issue 0x3C, 0x0C, 0x06, 0x01 in order with RS=0, RW=0.
  - Each window is CMD_HOLD cycles; 0x01 uses CLR_HOLD.
  - After the last window: init_done=1, go to IDLE.
  - Total from reset release to init_done high: INIT_DELAY + 3*CMD_HOLD + CLR_HOLD = 360 cycles at defaults.
- IDLE:
  - LCD_E=0, LCD_RW=1, LCD_RS and LCD_DATA hold their last values.
  - If any valid is high, exactly one readyN goes high that cycle. The transfer happens at that rising edge; rs/data are captured and the state moves to WRITE.
  - Arbitration:
    - One valid: it is granted.
    - Both valid: grant the requester other than last_grant; last_grant updates on every transfer.
- WRITE:
  - Window counter runs 0..H-1. H = CLR_HOLD if the captured rs=0 and data is 0x01 or 0x02; otherwise H = WR_HOLD.
  - LCD_RW=0 and LCD_RS/LCD_DATA equal the captured values for the whole window.
  - LCD_E=1 for counter values 1..H/2 inclusive, 0 otherwise. The same rule applies in INIT_CMD with its own H.
  - Both readys are 0. At the end of the window, return to IDLE.
  - Back-to-back writes are therefore separated by exactly one IDLE cycle.
- Requester rules:
  - valid must stay high with stable rs/data until ready.
  - valid may fall without ready (request withdrawn); no effect.
- Readys are 0 in INIT_WAIT and INIT_CMD; requests during init wait.
- Reset asserted mid-window aborts immediately to reset values, and the init sequence reruns in full.
- Counters are sized for the largest hold value and never wrap mid-window.

Optional Feature:
- Macro LCD_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid. last_grant is not used for arbitration; it may remain as a register.
- Undefined: round-robin as described above.
- All other behaviour is identical either way.

Decomposition:
- Shared package lcd_pkg:
  - State enum: INIT_WAIT, INIT_CMD, IDLE, WRITE.
  - Command constants: FUNC_SET 0x3C, DISP_ON 0x0C, ENTRY_MODE 0x06, CLEAR 0x01, HOME 0x02.
  - Default hold constants.
- One sub-module, lcd_write_timer:
  - Loads a hold length, counts the window, generates the LCD_E pulse and a done flag.
  - Instantiated once and shared by INIT_CMD and WRITE.

Test Plan:
- Reset release, no requests -> LCD_DATA sequence 0x3C, 0x0C, 0x06, 0x01 with window lengths 30/30/30/200; init_done rises 360 cycles after release; LCD_E pulses high 15, 15, 15, 100 cycles.
- After init, req0 rs=1 data=0x52 -> req0_ready high one cycle; next 20 cycles LCD_RS=1, LCD_RW=0, LCD_DATA=0x52, LCD_E high at window counts 1..10.
- Both valid continuously with distinct bytes -> accepted order req0, req1, req0, req1, with one IDLE cycle between windows. With LCD_ARB_FIXED_PRIO_EN defined -> req0 only until it drops valid.
- req1 rs=0 data=0x01 -> 200-cycle window; req1 rs=1 data=0x01 -> 20-cycle window.
- req0_valid asserted from reset release -> req0_ready stays 0 until init_done=1, then is accepted in the first IDLE cycle.
- RESETN pulsed low mid-WRITE (counter 7) -> outputs at reset values immediately; init sequence restarts; init_done=0 until 360 cycles after release.
